// File: rtl/ser_feed_pkg.sv
// Shared types and sizing helpers for the ser_feed parallel-to-serial feeder.
package ser_feed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Pace counter needs at least one bit even when DIV is 1 or 2.
    function automatic int unsigned pace_width(input int unsigned div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/strobe_div.sv
// Programmable strobe divider: one-cycle tick every DIV cycles while running,
// first tick on the cycle after restart.
module strobe_div
    import ser_feed_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk0,
    input  logic Ra,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int unsigned   PW   = pace_width(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] r_cnt;

    // Explicit wrap at DIV-1 so non-power-of-two dividers never overflow.
    always_ff @(posedge clk0 or posedge Ra) begin
        if (Ra) begin
            r_cnt <= '0;
        end else if (restart || !run) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign tick = run && (r_cnt == '0);

endmodule

// File: rtl/ser_feed.sv
// Parallel-to-serial feeder: MSB-first bit stream with paced en strobes,
// done pulse per word and a registered Rs pulse for the downstream flop.
module ser_feed
    import ser_feed_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 1
) (
    input  logic             clk0,
    input  logic             Ra,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             clear,
    output logic             D0,
    output logic             en,
    output logic             Rs,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   BW       = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [BW-1:0]    r_bitcnt;
    logic             r_rs;

    logic w_accept;
    logic w_run;
    logic w_restart;
    logic w_tick;

    assign w_accept  = (r_state == IDLE) && load_valid && !clear;
    assign w_run     = (r_state == SHIFT);
    assign w_restart = w_accept || clear;

    strobe_div #(
        .DIV(DIV)
    ) u_pace (
        .clk0   (clk0),
        .Ra     (Ra),
        .run    (w_run),
        .restart(w_restart),
        .tick   (w_tick)
    );

    // clear overrides every state transition, including a same-cycle load.
    always_ff @(posedge clk0 or posedge Ra) begin
        if (Ra) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_rs     <= 1'b0;
        end else begin
            r_rs <= clear;
            if (clear) begin
                r_state  <= IDLE;
                r_shreg  <= '0;
                r_bitcnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (load_valid) begin
                            r_shreg  <= load_data;
                            r_bitcnt <= BIT_LAST;
                            r_state  <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (w_tick) begin
                            if (r_bitcnt != '0) begin
                                r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
                                r_bitcnt <= r_bitcnt - BIT_ONE;
                            end else begin
                                r_shreg <= '0;
                                r_state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign load_ready = (r_state == IDLE);
    assign D0         = (r_state == SHIFT) && r_shreg[WIDTH-1];
    assign en         = w_tick;
    assign Rs         = r_rs;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);

endmodule
